// File: rtl/wash_pkg.sv
// Shared definitions for the washing-machine controller: state encoding and
// the field layout of the 26-bit programme / remaining-time word.
package wash_pkg;

  localparam logic [2:0] ST_SHUTDOWN = 3'd0;
  localparam logic [2:0] ST_BEGIN    = 3'd1;
  localparam logic [2:0] ST_SET      = 3'd2;
  localparam logic [2:0] ST_RUN      = 3'd3;
  localparam logic [2:0] ST_ERROR    = 3'd4;
  localparam logic [2:0] ST_PAUSE    = 3'd5;
  localparam logic [2:0] ST_FINISH   = 3'd6;

  typedef enum logic [2:0] {
    SHUTDOWN_ST = ST_SHUTDOWN,
    BEGIN_ST    = ST_BEGIN,
    SET_ST      = ST_SET,
    RUN_ST      = ST_RUN,
    ERROR_ST    = ST_ERROR,
    PAUSE_ST    = ST_PAUSE,
    FINISH_ST   = ST_FINISH
  } wash_state_e;

  localparam int MSG_W      = 26;
  localparam int NUM_FIELDS = 8;

  localparam int F0_MSB = 25;
  localparam int F0_LSB = 23;
  localparam int F1_MSB = 22;
  localparam int F1_LSB = 19;
  localparam int F2_MSB = 18;
  localparam int F2_LSB = 16;
  localparam int F3_MSB = 15;
  localparam int F3_LSB = 13;
  localparam int F4_MSB = 12;
  localparam int F4_LSB = 10;
  localparam int F5_MSB = 9;
  localparam int F5_LSB = 6;
  localparam int F6_MSB = 5;
  localparam int F6_LSB = 3;
  localparam int F7_MSB = 2;
  localparam int F7_LSB = 0;

  function automatic int field_lsb(input int idx);
    int lsb;
    case (idx)
      0:       lsb = F0_LSB;
      1:       lsb = F1_LSB;
      2:       lsb = F2_LSB;
      3:       lsb = F3_LSB;
      4:       lsb = F4_LSB;
      5:       lsb = F5_LSB;
      6:       lsb = F6_LSB;
      default: lsb = F7_LSB;
    endcase
    return lsb;
  endfunction

  function automatic int field_msb(input int idx);
    int msb;
    case (idx)
      0:       msb = F0_MSB;
      1:       msb = F1_MSB;
      2:       msb = F2_MSB;
      3:       msb = F3_MSB;
      4:       msb = F4_MSB;
      5:       msb = F5_MSB;
      6:       msb = F6_MSB;
      default: msb = F7_MSB;
    endcase
    return msb;
  endfunction

  function automatic logic [MSG_W-1:0] field_mask(input int idx);
    logic [MSG_W:0] w_hi;
    logic [MSG_W:0] w_lo;
    w_hi = (MSG_W+1)'(1) << (field_msb(idx) + 1);
    w_lo = (MSG_W+1)'(1) << field_lsb(idx);
    return MSG_W'(w_hi - w_lo);
  endfunction

endpackage

// File: rtl/wash_sequencer_tick_divider.sv
// Time-unit prescaler: counts 0..TICK_DIV-1 while enabled and emits a
// registered one-cycle tick in the cycle the count sits at TICK_DIV-1.
module tick_divider #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic cp,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nx;
  logic             r_tick;

  always_comb begin
    w_cnt_nx = (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
  end

  // Tick is registered from the next count so it coincides with r_cnt == LAST.
  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (clr || !en) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nx;
      r_tick <= (w_cnt_nx == LAST);
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/wash_sequencer.sv
// Programme sequencer: owns machine state and remaining-time word, counting
// fields down MSB-first. Door interlock is built only with WASH_DOOR_INTERLOCK_EN.
//
// state       | meaning
// SHUTDOWN_ST | powered off, only power_key is honoured
// BEGIN_ST    | power-on splash for BEGIN_TICKS time units
// SET_ST      | idle, waiting for start with a non-zero programme
// RUN_ST      | counting the active field down once per time unit
// ERROR_ST    | door opened while running, countdown held
// PAUSE_ST    | user pause, countdown held until start
// FINISH_ST   | buzzer on for FINISH_TICKS time units
module wash_sequencer
  import wash_pkg::*;
#(
  parameter int TICK_DIV     = 50_000_000,
  parameter int BEGIN_TICKS  = 2,
  parameter int FINISH_TICKS = 5
) (
  input  logic             cp,
  input  logic             rst_n,
  input  logic             power_key,
  input  logic             start_key,
  input  logic             door_open,
  input  logic [MSG_W-1:0] prog,
  output logic [2:0]       state,
  output logic [MSG_W-1:0] msg,
  output logic             tick,
  output logic             stage_done,
  output logic             buzzer
);

  localparam int UNITS_MAX = (BEGIN_TICKS > FINISH_TICKS) ? BEGIN_TICKS : FINISH_TICKS;
  localparam int UNITS_W   = $clog2(UNITS_MAX + 1);

  wash_state_e        r_state;
  wash_state_e        w_state_nx;
  logic [MSG_W-1:0]   r_msg;
  logic [MSG_W-1:0]   w_msg_nx;
  logic [MSG_W-1:0]   w_dec_step;
  logic [MSG_W-1:0]   w_msg_dec;
  logic               w_field_one;
  logic               r_stage_done;
  logic               w_stage_done_nx;
  logic               r_buzzer;
  logic [UNITS_W-1:0] r_units;
  logic               w_units_tc;
  logic               w_tick;
  logic               w_div_en;
  logic               w_state_chg;

`ifndef WASH_DOOR_INTERLOCK_EN
  logic w_unused_door;
  assign w_unused_door = door_open;
`endif

  tick_divider #(.TICK_DIV(TICK_DIV)) u_tick_divider (
    .cp    (cp),
    .rst_n (rst_n),
    .en    (w_div_en),
    .clr   (w_state_chg),
    .tick  (w_tick)
  );

  assign w_div_en    = (r_state == BEGIN_ST) || (r_state == RUN_ST) || (r_state == FINISH_ST);
  assign w_state_chg = (w_state_nx != r_state);
  assign w_units_tc  = (r_units == '0);

  // Active field is the lowest-numbered non-zero one; scanning from F7 up
  // lets the last hit win. Subtracting its LSB weight never borrows out.
  always_comb begin
    w_dec_step  = '0;
    w_field_one = 1'b0;
    for (int i = NUM_FIELDS - 1; i >= 0; i--) begin
      if ((r_msg & field_mask(i)) != '0) begin
        w_dec_step  = MSG_W'(1) << field_lsb(i);
        w_field_one = ((r_msg & field_mask(i)) == (MSG_W'(1) << field_lsb(i)));
      end
    end
    w_msg_dec = r_msg - w_dec_step;
  end

  always_comb begin
    w_state_nx      = r_state;
    w_msg_nx        = r_msg;
    w_stage_done_nx = 1'b0;
    if (r_state == SHUTDOWN_ST) begin
      if (power_key) w_state_nx = BEGIN_ST;
    end else if (power_key) begin
      w_state_nx = SHUTDOWN_ST;
      w_msg_nx   = '0;
    end else begin
      case (r_state)
        BEGIN_ST: begin
          if (w_tick && w_units_tc) w_state_nx = SET_ST;
        end
        SET_ST: begin
          if (start_key && (prog != '0)) begin
            w_state_nx = RUN_ST;
            w_msg_nx   = prog;
          end
        end
        RUN_ST: begin
`ifdef WASH_DOOR_INTERLOCK_EN
          if (door_open) w_state_nx = ERROR_ST;
          else
`endif
          if (start_key) begin
            w_state_nx = PAUSE_ST;
          end else if (w_tick) begin
            w_msg_nx        = w_msg_dec;
            w_stage_done_nx = w_field_one;
            if (w_msg_dec == '0) w_state_nx = FINISH_ST;
          end
        end
`ifdef WASH_DOOR_INTERLOCK_EN
        ERROR_ST: begin
          if (!door_open) w_state_nx = PAUSE_ST;
        end
`endif
        PAUSE_ST: begin
          if (start_key) w_state_nx = RUN_ST;
        end
        FINISH_ST: begin
          if (start_key || (w_tick && w_units_tc)) begin
            w_state_nx = SET_ST;
            w_msg_nx   = '0;
          end
        end
        default: w_state_nx = SHUTDOWN_ST;
      endcase
    end
  end

  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= SHUTDOWN_ST;
      r_msg        <= '0;
      r_stage_done <= 1'b0;
      r_buzzer     <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_msg        <= w_msg_nx;
      r_stage_done <= w_stage_done_nx;
      r_buzzer     <= (w_state_nx == FINISH_ST);
    end
  end

  // Unit timer is loaded on entry to a timed state and counts ticks down.
  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      r_units <= '0;
    end else if (w_state_chg) begin
      if (w_state_nx == BEGIN_ST)       r_units <= UNITS_W'(BEGIN_TICKS - 1);
      else if (w_state_nx == FINISH_ST) r_units <= UNITS_W'(FINISH_TICKS - 1);
      else                              r_units <= '0;
    end else if (w_tick && !w_units_tc) begin
      r_units <= r_units - UNITS_W'(1);
    end
  end

  assign state      = r_state;
  assign msg        = r_msg;
  assign tick       = w_tick;
  assign stage_done = r_stage_done;
  assign buzzer     = r_buzzer;

endmodule

// File: tb/tb_wash_sequencer.sv
// Bench for wash_sequencer: directed steps plus randomized programmes checked
// against a field-array model of the countdown.
module tb_wash_sequencer;

  localparam int TD = 4;
  localparam int BT = 2;
  localparam int FT = 2;
`ifdef WASH_DOOR_INTERLOCK_EN
  localparam bit IL = 1'b1;
`else
  localparam bit IL = 1'b0;
`endif

  logic        cp = 1'b0;
  logic        rst_n = 1'b1;
  logic        power_key = 1'b0;
  logic        start_key = 1'b0;
  logic        door_open = 1'b0;
  logic [25:0] prog = '0;
  logic [2:0]  state;
  logic [25:0] msg;
  logic        tick;
  logic        stage_done;
  logic        buzzer;

  int n_chk = 0;
  int n_pass = 0;
  int fw [8] = '{3, 4, 3, 3, 3, 4, 3, 3};
  int fv [8];

  always #5 cp = ~cp;

  wash_sequencer #(
    .TICK_DIV(TD), .BEGIN_TICKS(BT), .FINISH_TICKS(FT)
  ) dut (
    .cp(cp), .rst_n(rst_n), .power_key(power_key), .start_key(start_key),
    .door_open(door_open), .prog(prog), .state(state), .msg(msg),
    .tick(tick), .stage_done(stage_done), .buzzer(buzzer)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge cp);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic press_start();
    start_key = 1'b1; cyc(1); start_key = 1'b0;
  endtask

  task automatic press_power();
    power_key = 1'b1; cyc(1); power_key = 1'b0;
  endtask

  task automatic boot();
    press_power();
    chk("boot_begin", state, 1);
    cyc(BT * TD);
    chk("boot_set", state, 2);
  endtask

  function automatic logic [25:0] pack();
    logic [25:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) m = (m << fw[i]) | 26'(fv[i]);
    return m;
  endfunction

  function automatic bit all_zero();
    bit z;
    z = 1'b1;
    for (int i = 0; i < 8; i++) if (fv[i] != 0) z = 1'b0;
    return z;
  endfunction

  initial begin
    bit done;
    #2 rst_n = 1'b0;
    #2;
    chk("rst_state", state, 0);
    chk("rst_msg", msg, 0);
    chk("rst_tick", tick, 0);
    chk("rst_stage_done", stage_done, 0);
    chk("rst_buzzer", buzzer, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    press_start();
    chk("off_ignores_start", state, 0);

    press_power();
    chk("begin_entry", state, 1);
    for (int i = 1; i <= BT * TD; i++) begin
      cyc(1);
      chk("begin_tick", tick, (i % TD == TD - 1) ? 1 : 0);
      chk("begin_state", state, (i < BT * TD) ? 1 : 2);
    end
    chk("set_msg", msg, 0);

    prog = 26'h0;
    press_start();
    chk("zero_prog_state", state, 2);
    chk("zero_prog_msg", msg, 0);

    prog = 26'h9;
    press_start();
    chk("run_entry_state", state, 3);
    chk("run_entry_msg", msg, 26'h9);
    cyc(TD - 1);
    chk("run_hold_msg", msg, 26'h9);
    chk("run_hold_done", stage_done, 0);
    cyc(1);
    chk("run_dec1_msg", msg, 26'h1);
    chk("run_dec1_done", stage_done, 1);
    chk("run_dec1_state", state, 3);
    cyc(TD);
    chk("run_dec2_msg", msg, 0);
    chk("run_dec2_state", state, 6);
    chk("run_dec2_buzzer", buzzer, 1);
    chk("run_dec2_done", stage_done, 1);
    for (int i = 1; i <= FT * TD; i++) begin
      cyc(1);
      if (i == 1) chk("done_one_cycle", stage_done, 0);
      chk("finish_state", state, (i < FT * TD) ? 6 : 2);
      chk("finish_buzzer", buzzer, (i < FT * TD) ? 1 : 0);
    end

    prog = 26'h12;
    press_start();
    chk("pause_run_state", state, 3);
    cyc(1);
    press_start();
    chk("pause_state", state, 5);
    cyc(20);
    chk("pause_hold_state", state, 5);
    chk("pause_hold_msg", msg, 26'h12);
    press_start();
    chk("resume_state", state, 3);
    cyc(2);
    chk("resume_no_tick", tick, 0);
    cyc(1);
    chk("resume_tick", tick, 1);
    start_key = 1'b1; cyc(1); start_key = 1'b0;
    chk("tie_pause_state", state, 5);
    chk("tie_pause_msg", msg, 26'h12);
    press_start();
    cyc(TD - 1);
    chk("resume_hold_msg", msg, 26'h12);
    cyc(1);
    chk("resume_dec_msg", msg, 26'h0A);
    chk("resume_dec_done", stage_done, 0);

    cyc(3);
    chk("door_tick", tick, 1);
    door_open = 1'b1;
    cyc(1);
    chk("door_state", state, IL ? 4 : 3);
    chk("door_msg", msg, IL ? 26'h0A : 26'h02);
    chk("door_done", stage_done, IL ? 0 : 1);
    cyc(3);
    chk("door_hold_state", state, IL ? 4 : 3);
    chk("door_hold_msg", msg, IL ? 26'h0A : 26'h02);
    door_open = 1'b0;
    cyc(1);
    chk("door_close_state", state, IL ? 5 : 3);
    press_power();
    chk("power_off_state", state, 0);
    chk("power_off_msg", msg, 0);

    boot();
    prog = 26'h3800000;
    press_start();
    chk("f0_load_msg", msg, 26'h3800000);
    cyc(TD);
    chk("f0_dec_msg", msg, 26'h3000000);
    chk("f0_dec_done", stage_done, 0);
    press_power();
    chk("f0_power_state", state, 0);
    chk("f0_power_msg", msg, 0);
    chk("f0_power_tick", tick, 0);

    for (int it = 0; it < 6; it++) begin
      boot();
      for (int i = 0; i < 8; i++) fv[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2) : 0;
      if (all_zero()) fv[7] = 1;
      prog = pack();
      press_start();
      chk("rnd_load_state", state, 3);
      chk("rnd_load_msg", msg, pack());
      while (!all_zero()) begin
        if ($urandom_range(0, 3) == 0) begin
          cyc($urandom_range(0, TD - 1));
          start_key = 1'b1; cyc(1); start_key = 1'b0;
          chk("rnd_pause_state", state, 5);
          chk("rnd_pause_msg", msg, pack());
          cyc($urandom_range(0, 5));
          press_start();
          chk("rnd_resume_state", state, 3);
        end
        prog = 26'($urandom);
        cyc(TD - 1);
        chk("rnd_hold_msg", msg, pack());
        cyc(1);
        done = 1'b0;
        for (int i = 0; i < 8; i++) begin
          if (fv[i] != 0 && !done) begin
            fv[i] = fv[i] - 1;
            done = 1'b1;
            chk("rnd_stage_done", stage_done, (fv[i] == 0) ? 1 : 0);
          end
        end
        chk("rnd_dec_msg", msg, pack());
        chk("rnd_dec_state", state, all_zero() ? 6 : 3);
      end
      chk("rnd_buzzer", buzzer, 1);
      cyc($urandom_range(0, 5));
      press_start();
      chk("rnd_finish_skip_state", state, 2);
      chk("rnd_finish_skip_buzzer", buzzer, 0);
      press_power();
      chk("rnd_off_state", state, 0);
    end

    boot();
    prog = 26'h1;
    press_start();
    cyc(TD);
    chk("rst_fin_state_pre", state, 6);
    chk("rst_fin_buzzer_pre", buzzer, 1);
    rst_n = 1'b0;
    #2;
    chk("rst_fin_state", state, 0);
    chk("rst_fin_msg", msg, 0);
    chk("rst_fin_buzzer", buzzer, 0);
    chk("rst_fin_done", stage_done, 0);
    chk("rst_fin_tick", tick, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
